// File: rtl/assoc_search_ctrl_if.sv
// Bundle for assoc_search_ctrl: host request/result, memory read port and comparator hookup.
// slave = the search controller, master = the host/memory/comparator side.
interface assoc_search_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              start;
    logic [DATA_W-1:0] key;
    logic              busy;
    logic              done;
    logic              found;
    logic [ADDR_W-1:0] match_addr;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] cmp_key;
    logic              cmp_enable;
    logic              cmp_found;

    modport slave (
        input  start, key, mem_rdata, cmp_found,
        output busy, done, found, match_addr, mem_addr, mem_rd_en, cmp_key, cmp_enable
    );

    modport master (
        output start, key, mem_rdata, cmp_found,
        input  busy, done, found, match_addr, mem_addr, mem_rd_en, cmp_key, cmp_enable
    );
endinterface

// File: rtl/assoc_search_ctrl.sv
// Associative search sequencer: walks all DEPTH entries, stops at first comparator hit (LFSR_ADDR_SEQ_EN selects LFSR visit order).
// Latency: hit at visit k -> done in cycle 3+k after start; miss -> done in cycle DEPTH+2.
// Backpressure: none; start is ignored outside IDLE, one speculative read is discarded on a hit.
module assoc_search_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input logic                clk,
    input logic                rst_n,
    assoc_search_ctrl_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(DEPTH - 1);

    logic [1:0]        state;
    logic [DATA_W-1:0] key_q;
    logic [ADDR_W-1:0] issue_addr;
    logic [ADDR_W-1:0] issue_cnt;
    logic              rd_en_q;
    logic              valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic              found_q;
    logic [ADDR_W-1:0] match_q;
    logic [ADDR_W-1:0] addr_next;
    logic [ADDR_W-1:0] first_addr;

`ifdef LFSR_ADDR_SEQ_EN
    localparam logic [7:0] TAP_MASK = (ADDR_W == 3) ? 8'h06 :
                                      (ADDR_W == 4) ? 8'h0C :
                                      (ADDR_W == 5) ? 8'h14 :
                                      (ADDR_W == 6) ? 8'h30 :
                                      (ADDR_W == 7) ? 8'h60 : 8'hB8;
    localparam logic [ADDR_W-1:0] PENULT_CNT = ADDR_W'(DEPTH - 2);

    // The LFSR never reaches 0, so address 0 is forced in as the final visit.
    assign first_addr = ADDR_W'(1);
    assign addr_next  = (issue_cnt == PENULT_CNT) ? '0
                      : {issue_addr[ADDR_W-2:0], ^(issue_addr & TAP_MASK[ADDR_W-1:0])};
`else
    assign first_addr = '0;
    assign addr_next  = issue_addr + 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            key_q      <= '0;
            issue_addr <= '0;
            issue_cnt  <= '0;
            rd_en_q    <= 1'b0;
            valid_q    <= 1'b0;
            addr_q     <= '0;
            found_q    <= 1'b0;
            match_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    valid_q <= 1'b0;
                    if (bus.start) begin
                        key_q      <= bus.key;
                        found_q    <= 1'b0;
                        match_q    <= '0;
                        issue_addr <= first_addr;
                        issue_cnt  <= '0;
                        rd_en_q    <= 1'b1;
                        state      <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    valid_q <= rd_en_q;
                    addr_q  <= issue_addr;
                    if (valid_q && bus.cmp_found) begin
                        found_q <= 1'b1;
                        match_q <= addr_q;
                        rd_en_q <= 1'b0;
                        valid_q <= 1'b0;
                        state   <= ST_DONE;
                    end else if (valid_q && !rd_en_q) begin
                        // Last entry compared without a hit.
                        state <= ST_DONE;
                    end else if (rd_en_q) begin
                        if (issue_cnt == LAST_CNT) begin
                            rd_en_q <= 1'b0;
                        end else begin
                            issue_addr <= addr_next;
                            issue_cnt  <= issue_cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    valid_q <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    rd_en_q <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = (state == ST_SCAN);
    assign bus.done       = (state == ST_DONE);
    assign bus.found      = found_q;
    assign bus.match_addr = match_q;
    assign bus.mem_addr   = issue_addr;
    assign bus.mem_rd_en  = rd_en_q;
    assign bus.cmp_key    = key_q;
    assign bus.cmp_enable = valid_q;
endmodule

// File: tb/tb_assoc_search_ctrl.sv
// Bench for assoc_search_ctrl: behavioural memory + comparator, scoreboard of expected search results.
module tb_assoc_search_ctrl;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    assoc_search_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    assoc_search_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata = '0;

    always @(posedge clk) if (bus.mem_rd_en) rdata <= mem[bus.mem_addr];
    assign bus.mem_rdata = rdata;
    assign bus.cmp_found = bus.cmp_enable && (bus.cmp_key == rdata);

    typedef struct {
        bit         found;
        logic [3:0] addr;
        int         done_cyc;
        int         reads;
        int         cmps;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [3:0] visit_addr(input int k);
`ifdef LFSR_ADDR_SEQ_EN
        case (k)
            0: return 4'd1;   1: return 4'd2;   2: return 4'd4;   3: return 4'd9;
            4: return 4'd3;   5: return 4'd6;   6: return 4'd13;  7: return 4'd10;
            8: return 4'd5;   9: return 4'd11;  10: return 4'd7;  11: return 4'd15;
            12: return 4'd14; 13: return 4'd12; 14: return 4'd8;  default: return 4'd0;
        endcase
`else
        return 4'(k);
`endif
    endfunction

    task automatic run_search(input logic [7:0] k, input bit hold, input bit toggle, input string tag);
        exp_t e, got;
        int idx = -1;
        int cyc, reads, cmps;
        bit seq_ok, key_ok, busy_ok;
        for (int v = DEPTH - 1; v >= 0; v--) if (mem[visit_addr(v)] == k) idx = v;
        e.found    = (idx >= 0);
        e.addr     = (idx >= 0) ? visit_addr(idx) : 4'd0;
        e.done_cyc = (idx >= 0) ? 3 + idx : DEPTH + 2;
        e.reads    = (idx >= 0) ? ((idx + 2 > DEPTH) ? DEPTH : idx + 2) : DEPTH;
        e.cmps     = (idx >= 0) ? idx + 1 : DEPTH;
        sb.push_back(e);

        @(negedge clk);
        bus.start = 1'b1;
        bus.key   = k;
        @(posedge clk); #1;
        if (!hold) bus.start = 1'b0;
        cyc = 1; reads = 0; cmps = 0;
        seq_ok = 1'b1; key_ok = 1'b1; busy_ok = 1'b1;
        while (bus.done !== 1'b1 && cyc <= 3 * DEPTH) begin
            if (toggle) bus.key = bus.key ^ 8'hFF;
            if (bus.mem_rd_en === 1'b1) begin
                if (bus.mem_addr !== visit_addr(reads)) seq_ok = 1'b0;
                reads++;
            end
            if (bus.cmp_enable === 1'b1) cmps++;
            if (bus.cmp_key !== k) key_ok = 1'b0;
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        bus.start = 1'b0;

        got = sb.pop_front();
        n_checks++;
        if (bus.done !== 1'b1) $display("FAIL %s done_seen: no done within %0d cycles", tag, 3 * DEPTH);
        else n_pass++;
        n_checks++;
        if (cyc !== got.done_cyc) $display("FAIL %s done_cycle: got %0d want %0d", tag, cyc, got.done_cyc);
        else n_pass++;
        n_checks++;
        if (bus.found !== got.found) $display("FAIL %s found: got %b want %b", tag, bus.found, got.found);
        else n_pass++;
        n_checks++;
        if (bus.match_addr !== got.addr) $display("FAIL %s match_addr: got %0d want %0d", tag, bus.match_addr, got.addr);
        else n_pass++;
        n_checks++;
        if (reads !== got.reads) $display("FAIL %s read_count: got %0d want %0d", tag, reads, got.reads);
        else n_pass++;
        n_checks++;
        if (cmps !== got.cmps) $display("FAIL %s cmp_enable_count: got %0d want %0d", tag, cmps, got.cmps);
        else n_pass++;
        n_checks++;
        if ({seq_ok, key_ok, busy_ok} !== 3'b111)
            $display("FAIL %s addr_seq/key/busy: got %b%b%b want 111", tag, seq_ok, key_ok, busy_ok);
        else n_pass++;
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL %s busy_in_done: got %b want 0", tag, bus.busy);
        else n_pass++;

        @(posedge clk); #1;
        n_checks++;
        if ({bus.done, bus.busy, bus.found, bus.match_addr} !== {2'b00, got.found, got.addr})
            $display("FAIL %s after_done: got done=%b busy=%b found=%b addr=%0d want 0 0 %b %0d",
                     tag, bus.done, bus.busy, bus.found, bus.match_addr, got.found, got.addr);
        else n_pass++;
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.key   = '0;
        rst_n     = 1'b0;
        #12;
        n_checks++;
        if ({bus.busy, bus.done, bus.found, bus.match_addr, bus.mem_addr, bus.mem_rd_en, bus.cmp_key, bus.cmp_enable} !== 24'h0)
            $display("FAIL reset_state: got %h want 0",
                     {bus.busy, bus.done, bus.found, bus.match_addr, bus.mem_addr, bus.mem_rd_en, bus.cmp_key, bus.cmp_enable});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_linear_hit();
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i * 3);
        run_search(8'd15, 1'b0, 1'b0, "hit_15");
    endtask

    task automatic test_miss();
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'hAA;
        run_search(8'h55, 1'b0, 1'b0, "miss");
    endtask

    task automatic test_first_entry();
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i);
        mem[0] = 8'h3C;
        mem[9] = 8'h3C;
        run_search(8'h3C, 1'b0, 1'b0, "first_entry");
    endtask

    task automatic test_hold_toggle_back_to_back();
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i * 3);
        run_search(8'd15, 1'b1, 1'b1, "hold_toggle");
        run_search(8'd30, 1'b0, 1'b0, "back_to_back");
    endtask

    task automatic test_mid_reset();
        bit saw_done = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'hAA;
        @(negedge clk);
        bus.start = 1'b1;
        bus.key   = 8'h55;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 1; c < 6; c++) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.busy, bus.done, bus.found, bus.match_addr, bus.mem_addr, bus.mem_rd_en, bus.cmp_key, bus.cmp_enable} !== 24'h0)
            $display("FAIL mid_reset_state: got %h want 0",
                     {bus.busy, bus.done, bus.found, bus.match_addr, bus.mem_addr, bus.mem_rd_en, bus.cmp_key, bus.cmp_enable});
        else n_pass++;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0) saw_done = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done !== 1'b0) $display("FAIL mid_reset_no_done: got done pulse want none");
        else n_pass++;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i * 3);
        run_search(8'd42, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_addr_order();
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
        mem[13] = 8'h77;
        run_search(8'h77, 1'b0, 1'b0, "addr_order_13");
    endtask

    initial begin
        test_reset();
        test_linear_hit();
        test_miss();
        test_first_entry();
        test_hold_toggle_back_to_back();
        test_mid_reset();
        test_addr_order();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
